// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, ALU operation
// codes, datapath mux selects and the opcodes the controller recognises.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   // What the FSM asks of the ALU; FUNCT defers to funct3/funct7b5.
   typedef enum logic [1:0] {
      ALU_REQ_ADD   = 2'd0,
      ALU_REQ_SUB   = 2'd1,
      ALU_REQ_FUNCT = 2'd2
   } alu_req_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;
   localparam logic [1:0] SRC_B_RS2   = 2'b00;
   localparam logic [1:0] SRC_B_IMM   = 2'b01;
   localparam logic [1:0] SRC_B_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
interface multicycle_control_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_control;
   logic       halted;

   modport master (
      input  opcode, funct3, funct7b5, zero,
      output pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, imm_src, alu_control, halted
   );

   modport slave (
      output opcode, funct3, funct7b5, zero,
      input  pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, imm_src, alu_control, halted
   );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALU request plus funct fields to an alu_control code, and flags
// R/I-type funct encodings the ALU cannot execute.
module alu_decoder
   import multicycle_control_pkg::*;
(
   input  alu_req_t   alu_req,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control,
   output logic       illegal
);
   logic [2:0] funct_op;

   // op5 separates R-type (sub possible) from I-type, where bit 30 is immediate data.
   always_comb begin
      funct_op = ALU_ADD;
      unique case (funct3)
         3'b000:  funct_op = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  funct_op = ALU_SLL;
         3'b010:  funct_op = ALU_SLT;
         3'b100:  funct_op = ALU_XOR;
         3'b101:  funct_op = ALU_SRL;
         3'b110:  funct_op = ALU_OR;
         3'b111:  funct_op = ALU_AND;
         default: funct_op = ALU_ADD;
      endcase
   end

   assign illegal = (funct3 == 3'b011) || ((funct3 == 3'b101) && funct7b5);

   always_comb begin
      alu_control = ALU_ADD;
      unique case (alu_req)
         ALU_REQ_SUB:   alu_control = ALU_SUB;
         ALU_REQ_FUNCT: alu_control = funct_op;
         default:       alu_control = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/multicycle_control.sv
// Moore-style main controller for a multicycle RV32 subset (lw, sw, R, I-ALU,
// beq/bne, jal); unsupported instructions park the core in TRAP until reset.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);
   state_t     state_q, state_d;
   alu_req_t   alu_req;
   logic [2:0] alu_control;
   logic       funct_illegal;
   logic       word_f3;

   alu_decoder u_alu_decoder (
      .alu_req    (alu_req),
      .funct3     (bus.funct3),
      .funct7b5   (bus.funct7b5),
      .op5        (bus.opcode[5]),
      .alu_control(alu_control),
      .illegal    (funct_illegal)
   );

   assign bus.alu_control = alu_control;
   assign word_f3         = (bus.funct3 == F3_WORD);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            state_d = S_TRAP;
            if      ((bus.opcode == OP_LW || bus.opcode == OP_SW) && word_f3) state_d = S_MEMADR;
            else if (bus.opcode == OP_R && !funct_illegal)                   state_d = S_EXECR;
            else if (bus.opcode == OP_I && !funct_illegal)                   state_d = S_EXECI;
            else if (bus.opcode == OP_BR && bus.funct3[2:1] == 2'b00)        state_d = S_BRANCH;
            else if (bus.opcode == OP_JAL)                                   state_d = S_JAL;
         end
         S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI,
         S_JAL:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      bus.pc_write   = 1'b0;
      bus.adr_src    = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.result_src = RES_ALUOUT;
      bus.alu_src_a  = SRC_A_PC;
      bus.alu_src_b  = SRC_B_RS2;
      bus.halted     = 1'b0;
      alu_req        = ALU_REQ_ADD;
      unique case (state_q)
         S_FETCH: begin
            bus.ir_write   = 1'b1;
            bus.pc_write   = 1'b1;
            bus.alu_src_b  = SRC_B_FOUR;
            bus.result_src = RES_ALU;
         end
         S_DECODE: begin
            bus.alu_src_a = SRC_A_OLDPC;
            bus.alu_src_b = SRC_B_IMM;
         end
         S_MEMADR: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
         end
         S_MEMREAD: bus.adr_src = 1'b1;
         S_MEMWB: begin
            bus.result_src = RES_MEMDATA;
            bus.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            bus.adr_src   = 1'b1;
            bus.mem_write = 1'b1;
         end
         S_EXECR: begin
            bus.alu_src_a = SRC_A_RS1;
            alu_req       = ALU_REQ_FUNCT;
         end
         S_EXECI: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
            alu_req       = ALU_REQ_FUNCT;
         end
         S_ALUWB: bus.reg_write = 1'b1;
         S_BRANCH: begin
            bus.alu_src_a = SRC_A_RS1;
            alu_req       = ALU_REQ_SUB;
            bus.pc_write  = bus.zero ^ bus.funct3[0];
         end
         S_JAL: begin
            bus.alu_src_a = SRC_A_OLDPC;
            bus.alu_src_b = SRC_B_FOUR;
            bus.pc_write  = 1'b1;
         end
         S_TRAP:  bus.halted = 1'b1;
         default: ;
      endcase
      // Reset suppresses every architectural write even before the state register settles.
      if (reset) begin
         bus.pc_write  = 1'b0;
         bus.ir_write  = 1'b0;
         bus.mem_write = 1'b0;
         bus.reg_write = 1'b0;
         bus.halted    = 1'b0;
      end
   end

   always_comb begin
      bus.imm_src = IMM_I;
      unique case (bus.opcode)
         OP_SW:   bus.imm_src = IMM_S;
         OP_BR:   bus.imm_src = IMM_B;
         OP_JAL:  bus.imm_src = IMM_J;
         default: bus.imm_src = IMM_I;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, directed corner sequences and random
// instructions compared per cycle against an instruction-level reference model.
module tb_multicycle_control;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] imm_src;
      logic       halted;
   } ctl_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      int         len;
      logic [2:0] alu2;
      logic       pcw2;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   ctl_t exp_q[$];
   logic [2:0] f3_op [8];
   vec_t vecs [15];

   always #5 clk = ~clk;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   function automatic ctl_t actual();
      ctl_t c;
      c.pc_write    = bus.pc_write;
      c.adr_src     = bus.adr_src;
      c.mem_write   = bus.mem_write;
      c.ir_write    = bus.ir_write;
      c.reg_write   = bus.reg_write;
      c.result_src  = bus.result_src;
      c.alu_src_a   = bus.alu_src_a;
      c.alu_src_b   = bus.alu_src_b;
      c.alu_control = bus.alu_control;
      c.imm_src     = bus.imm_src;
      c.halted      = bus.halted;
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected per-cycle outputs of one instruction, starting at its fetch cycle.
   task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input int trap_cycles, output bit trapped);
      ctl_t base, c;
      logic [2:0] fop;
      bit is_r, is_i;
      base = '0;
      base.imm_src = (op == 7'b0100011) ? 2'b01 :
                     (op == 7'b1100011) ? 2'b10 :
                     (op == 7'b1101111) ? 2'b11 : 2'b00;
      fop  = (f3 == 3'b000 && op == 7'b0110011 && f7) ? 3'b001 : f3_op[f3];
      is_r = (op == 7'b0110011) && f3 != 3'b011 && !(f3 == 3'b101 && f7);
      is_i = (op == 7'b0010011) && f3 != 3'b011 && !(f3 == 3'b101 && f7);
      trapped = 1'b0;
      c = base; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
      exp_q.push_back(c);
      c = base; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
      exp_q.push_back(c);
      if ((op == 7'b0000011 || op == 7'b0100011) && f3 == 3'b010) begin
         c = base; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
         exp_q.push_back(c);
         if (op == 7'b0000011) begin
            c = base; c.adr_src = 1; exp_q.push_back(c);
            c = base; c.result_src = 2'b01; c.reg_write = 1; exp_q.push_back(c);
         end else begin
            c = base; c.adr_src = 1; c.mem_write = 1; exp_q.push_back(c);
         end
      end else if (is_r || is_i) begin
         c = base; c.alu_src_a = 2'b10; c.alu_src_b = is_i ? 2'b01 : 2'b00; c.alu_control = fop;
         exp_q.push_back(c);
         c = base; c.reg_write = 1; exp_q.push_back(c);
      end else if (op == 7'b1100011 && f3 <= 3'b001) begin
         c = base; c.alu_src_a = 2'b10; c.alu_control = 3'b001; c.pc_write = z ^ f3[0];
         exp_q.push_back(c);
      end else if (op == 7'b1101111) begin
         c = base; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1;
         exp_q.push_back(c);
         c = base; c.reg_write = 1; exp_q.push_back(c);
      end else begin
         trapped = 1'b1;
         for (int k = 0; k < trap_cycles; k++) begin
            c = base; c.halted = 1; exp_q.push_back(c);
         end
      end
   endtask

   task automatic set_inputs(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
      bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
      #1;
   endtask

   // Entered just after the negedge of a fetch cycle; leaves after the next one.
   task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic z, input int trap_cycles, output bit trapped);
      int i;
      ctl_t e;
      set_inputs(op, f3, f7, z);
      exp_q.delete();
      model(op, f3, f7, z, trap_cycles, trapped);
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (i > 0) @(negedge clk);
         check($sformatf("%s cyc%0d", name, i), 32'(actual()), 32'(e));
         i++;
      end
      @(negedge clk);
   endtask

   task automatic reset_recover(input string name);
      reset = 1'b1;
      #1;
      check({name, " rst_en"}, 32'({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.halted}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check({name, " fetch_irw"}, 32'(bus.ir_write), 32'd1);
   endtask

   initial begin
      bit   trapped;
      int   n;
      logic [2:0] alu2;
      logic pcw2;
      logic [6:0] ops [8];
      logic [6:0] rop;

      f3_op = '{3'b000, 3'b100, 3'b101, 3'b000, 3'b111, 3'b110, 3'b011, 3'b010};
      ops   = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1110011, 7'b0000000};
      vecs = '{
         '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0},
         '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 1'b0},
         '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 1'b0},
         '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0},
         '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0},
         '{7'b0110011, 3'b100, 1'b0, 1'b0, 4, 3'b111, 1'b0},
         '{7'b0110011, 3'b001, 1'b0, 1'b0, 4, 3'b100, 1'b0},
         '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0},
         '{7'b0010011, 3'b101, 1'b0, 1'b0, 4, 3'b110, 1'b0},
         '{7'b0010011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 1'b0},
         '{7'b1100011, 3'b001, 1'b0, 1'b0, 3, 3'b001, 1'b1},
         '{7'b1100011, 3'b001, 1'b0, 1'b1, 3, 3'b001, 1'b0},
         '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1},
         '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0},
         '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b1}
      };

      reset = 1'b1;
      bus.opcode = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("reset en c%0d", k),
               32'({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.halted}), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post-reset ir_write", 32'(bus.ir_write), 32'd1);
      check("post-reset pc_write", 32'(bus.pc_write), 32'd1);
      check("post-reset alu", 32'(bus.alu_control), 32'd0);

      run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 0, trapped);

      foreach (vecs[v]) begin
         set_inputs(vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].z);
         n = 0; alu2 = 'x; pcw2 = 'x;
         do begin
            @(negedge clk);
            n++;
            if (n == 2) begin alu2 = bus.alu_control; pcw2 = bus.pc_write; end
         end while (!bus.ir_write && n < 10);
         check($sformatf("vec%0d len", v), 32'(n), 32'(vecs[v].len));
         check($sformatf("vec%0d alu", v), 32'(alu2), 32'(vecs[v].alu2));
         check($sformatf("vec%0d pcw", v), 32'(pcw2), 32'(vecs[v].pcw2));
      end

      // sltu is not supported: controller must halt and stay quiet until reset.
      run("sltu", 7'b0110011, 3'b011, 1'b0, 1'b0, 10, trapped);
      check("sltu trapped", 32'(trapped), 32'd1);
      check("sltu halted", 32'(bus.halted), 32'd1);
      reset_recover("sltu");

      // Reset landing in MEMREAD must abandon the load before its write-back.
      set_inputs(7'b0000011, 3'b010, 1'b0, 1'b0);
      exp_q.delete();
      model(7'b0000011, 3'b010, 1'b0, 1'b0, 0, trapped);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("lw-abort cyc%0d", k), 32'(actual()), 32'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
      check("lw-abort memread adr", 32'(bus.adr_src), 32'd1);
      reset = 1'b1;
      #1;
      check("lw-abort rst reg_write", 32'(bus.reg_write), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("lw-abort fetch irw", 32'(bus.ir_write), 32'd1);
      check("lw-abort fetch regw", 32'(bus.reg_write), 32'd0);

      for (int r = 0; r < 60; r++) begin
         rop = ops[$urandom_range(0, 7)];
         run($sformatf("rnd%0d op%0h", r, rop), rop, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, trapped);
         if (trapped) reset_recover($sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared constants file.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instr[6:0] from instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag, sum==0.
REQ-008 pc_write  output  1  PC register enable.
REQ-009 adr_src  output  1  memory address select: 0 PC, 1 registered ALU result.
REQ-010 mem_write, ir_write, reg_write  output  1 each  memory, instruction-register and register-file write enables.
REQ-011 result_src  output  2  00 registered ALU result, 01 memory data, 10 live ALU result.
REQ-012 alu_src_a  output  2  00 PC, 01 old PC, 10 rs1 data; alu_src_b  output  2  00 rs2 data, 01 immediate, 10 constant 4.
REQ-013 imm_src  output  2  00 I, 01 S, 10 B, 11 J.
REQ-014 alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 srl, 111 xor.
REQ-015 halted  output  1  high while in TRAP.

Function
REQ-016 SHALL be a Moore FSM; 4-bit state: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11; codes 12-15 go to FETCH.
REQ-017 Legal set: lw (0000011/010), sw (0100011/010), R (0110011), I-ALU (0010011), beq/bne (1100011, funct3 000/001), jal (1101111).
REQ-018 R/I funct3 mapping: 000 add (sub if R and funct7b5), 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and; 011, and 101 with funct7b5=1, are illegal.
REQ-019 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECR, EXECI, BRANCH, JAL, or TRAP (illegal); MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECR, EXECI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH; TRAP->TRAP.
REQ-020 FETCH: adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1.
REQ-021 DECODE: a=01, b=01, add (branch target precompute).
REQ-022 MEMADR: a=10, b=01, add; MEMREAD: adr_src=1; MEMWB: result_src=01, reg_write=1; MEMWRITE: adr_src=1, mem_write=1.
REQ-023 EXECR: a=10, b=00, decoded op; EXECI: a=10, b=01, decoded op; ALUWB: result_src=00, reg_write=1.
REQ-024 BRANCH: a=10, b=00, sub, result_src=00; pc_write = zero XOR funct3[0].
REQ-025 JAL: a=01, b=10, add, result_src=00, pc_write=1.
REQ-026 imm_src SHALL be decoded from opcode in every state; unused mux selects 00; unlisted enables 0.
REQ-027 Cycle counts, FETCH to next FETCH: lw 5, sw 4, R 4, I 4, branch 3, jal 4.
REQ-028 TRAP: all enables 0, halted=1, held until reset.

Reset
REQ-029 reset high at a clock edge SHALL load FETCH, overriding any in-flight transition.
REQ-030 While reset is high, pc_write, ir_write, mem_write and reg_write SHALL be forced 0 and halted 0.
REQ-031 First cycle after reset release SHALL present the FETCH outputs.

Structure
REQ-032 State codes, alu_control codes, mux-select codes and opcodes SHALL live in the shared constants file, which ALU users also include.
REQ-033 A combinational sub-module alu_decoder SHALL map the FSM ALU request (add, sub, funct-decoded) plus funct3/funct7b5/opcode[5] to alu_control and an illegal flag.

Verification
REQ-034 reset high 2 cycles -> all enables 0; after release, first cycle ir_write=1, pc_write=1, alu_control=000.
REQ-035 lw (opcode 0000011, funct3 010) -> states 0,1,2,3,4; reg_write=1 only in MEMWB, result_src=01 there.
REQ-036 sub (R, funct3 000, funct7b5=1) -> EXECR with alu_control=001; or (funct3 110) -> 011; slt (010) -> 101.
REQ-037 bne (funct3 001), zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0; back to FETCH after 3 cycles total.
REQ-038 sltu (R, funct3 011) -> TRAP, halted=1, no write enables for 10 cycles; reset -> FETCH.
REQ-039 reset asserted while in MEMREAD -> next state FETCH, reg_write never asserted for that lw.
